apb_gpio_bank: RTL and testbench
================================

Name: apb_gpio_bank

Overview:
- APB responder holding one GPIO bank of the SPI GPIO expander; one instance sits behind each psel bit driven by the SPI-to-APB bridge.
- Decodes 3-bit register addresses, inserts a configurable number of wait states, then asserts pready and commits the write or drives read data.
- Owns output data and direction, samples and synchronises input pins, detects edges and raises a level interrupt.

Parameters:
- DATA_WIDTH, 8, width of pwdata/prdata and of every register (one bit per GPIO pin).
- ADDR_WIDTH, 3, width of paddr; 8 register slots.
- WAIT_STATES, 1, access-phase cycles with pready low before the pready cycle (0..15).

Ports:
- pclk  in  1  APB clock (the bridge's b_pclk).
- reset  in  1  synchronous, active-high reset.
- psel  in  1  bank select (one bit of the bridge's b_psel).
- penable  in  1  APB access phase.
- pwrite  in  1  1=write, 0=read.
- paddr  in  ADDR_WIDTH  register address.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data; valid only while pready=1, else 0.
- pready  out  1  transfer complete; high for exactly one cycle per access.
- gpio_in  in  DATA_WIDTH  asynchronous pin inputs.
- gpio_out  out  DATA_WIDTH  pin output values.
- gpio_oe  out  DATA_WIDTH  per-pin output enable, 1=drive.
- irq  out  1  level interrupt, |(IRQ_STATUS & IRQ_EN).

Behaviour:
- Clock and reset:
  - Single clock pclk; reset is synchronous and active-high.
  - In reset: all registers 0, both sync flops 0, FSM=IDLE, pready=0, prdata=0, gpio_out=0, gpio_oe=0, irq=0.
  - Reset mid-transfer aborts the transfer with no write.
- Register map (write=W, read=R):
  - 0 DATA_OUT: R/W; drives gpio_out.
  - 1 DIR: R/W; drives gpio_oe.
  - 2 DATA_IN: read-only, synchronised pins; writes ignored.
  - 3 IRQ_EN: R/W.
  - 4 IRQ_STATUS: R; write-1-to-clear.
  - 5 IRQ_EDGE: R/W; per bit, 1=rising edge, 0=falling edge.
  - 6 OUT_SET: W sets DATA_OUT |= pwdata; reads 0.
  - 7 OUT_CLR: W clears DATA_OUT &= ~pwdata; reads 0.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: when psel & penable are sampled high, latch paddr, pwrite, pwdata. Go to DONE if WAIT_STATES==0, else go to WAIT with cnt=0. An access-phase entry without a prior setup cycle is still accepted.
  - WAIT: cnt increments each cycle; at cnt==WAIT_STATES-1 go to DONE. If psel drops, return to IDLE with no write and no pready.
  - DONE: pready=1 and prdata=mux(latched addr), both registered outputs valid this cycle. A write commits at the edge ending DONE. The next state is always IDLE, so back-to-back accesses need penable to drop for at least one cycle.
- Latency: pready rises WAIT_STATES+1 cycles after the first cycle with psel & penable high.
- Input path:
  - Two-flop synchroniser on gpio_in feeds DATA_IN (2-cycle latency).
  - A third flop (previous value) feeds edge detection.
  - Rising event = sync & ~prev; falling event = ~sync & prev; selected per bit by IRQ_EDGE.
  - An event sets the matching IRQ_STATUS bit regardless of IRQ_EN.
- Simultaneous events:
  - Hardware set and W1C on the same bit in the same cycle: set wins (bit stays 1).
  - irq updates the cycle after the IRQ_STATUS or IRQ_EN change (registered).
- DATA_OUT holds its value when DIR=0. gpio_out is not gated by DIR; the pad uses gpio_oe.

Test Plan:
- Write then read: WAIT_STATES=1, write DATA_OUT=0xA5, then read addr 0 → pready one cycle at cycle 2 of each access; gpio_out=0xA5 after the write DONE; prdata=0xA5 during the read pready; prdata=0 otherwise.
- Set/clear: DATA_OUT=0x0F, write OUT_SET=0xF0, then OUT_CLR=0x81 → gpio_out 0xFF then 0x7E; reads of addr 6/7 return 0.
- Edge interrupt: IRQ_EDGE=0x01, IRQ_EN=0x03; gpio_in[0] 0→1 and gpio_in[1] 1→0 → IRQ_STATUS=0x03 three cycles later, irq=1; write IRQ_STATUS=0x01 → status 0x02, irq stays 1; write 0x02 → irq=0.
- Set/clear collision: a pin edge lands on the same cycle as W1C of that bit → bit remains 1.
- Abort and reset: drop psel in WAIT → no pready, registers unchanged; assert reset during DONE of a write → no write, all outputs 0 next cycle.
- Zero wait: WAIT_STATES=0 → pready in the cycle after penable rises; DATA_IN reads gpio_in=0x3C two cycles after it is applied.

Source files
------------

// File: rtl/apb_gpio_bank.sv
// APB GPIO bank: one register bank of the SPI GPIO expander.
// Holds output data/direction, synchronises input pins, detects per-pin
// edges into a sticky status register and raises a level interrupt.
module apb_gpio_bank #(
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 3,
   parameter int WAIT_STATES = 1
) (
   input  logic                  pclk,
   input  logic                  reset,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   input  logic [DATA_WIDTH-1:0] gpio_in,
   output logic [DATA_WIDTH-1:0] gpio_out,
   output logic [DATA_WIDTH-1:0] gpio_oe,
   output logic                  irq
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] A_DATA_OUT   = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_DIR        = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_DATA_IN    = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_IRQ_EN     = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] A_IRQ_STATUS = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] A_IRQ_EDGE   = ADDR_WIDTH'(5);
   localparam logic [ADDR_WIDTH-1:0] A_OUT_SET    = ADDR_WIDTH'(6);
   localparam logic [ADDR_WIDTH-1:0] A_OUT_CLR    = ADDR_WIDTH'(7);

   // Last wait-state count value; unused when WAIT_STATES is zero.
   localparam int              CNT_LAST_I = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam logic [3:0]      CNT_LAST   = 4'(CNT_LAST_I);

   state_t                  state_reg, state_next;
   logic [3:0]              cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0]   addr_reg, addr_next;
   logic                    write_reg, write_next;
   logic [DATA_WIDTH-1:0]   wdata_reg, wdata_next;

   logic [DATA_WIDTH-1:0]   data_out_reg, data_out_next;
   logic [DATA_WIDTH-1:0]   dir_reg, dir_next;
   logic [DATA_WIDTH-1:0]   irq_en_reg, irq_en_next;
   logic [DATA_WIDTH-1:0]   irq_status_reg, irq_status_next;
   logic [DATA_WIDTH-1:0]   irq_edge_reg, irq_edge_next;
   logic [DATA_WIDTH-1:0]   w1c_mask;

   logic [DATA_WIDTH-1:0]   sync1_reg, sync2_reg, prev_reg;
   logic [DATA_WIDTH-1:0]   event_vec;
   logic [DATA_WIDTH-1:0]   rd_data;
   logic [DATA_WIDTH-1:0]   prdata_reg;
   logic                    pready_reg;
   logic                    irq_reg;

   // Per-pin edge event, polarity chosen by the matching IRQ_EDGE bit.
   for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_edge
      assign event_vec[gi] = irq_edge_reg[gi] ? (sync2_reg[gi] & ~prev_reg[gi])
                                              : (~sync2_reg[gi] & prev_reg[gi]);
   end

   // Transfer FSM next state; the request is latched on entry from IDLE.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      addr_next  = addr_reg;
      write_next = write_reg;
      wdata_next = wdata_reg;
      case (state_reg)
         IDLE: begin
            if (psel && penable) begin
               addr_next  = paddr;
               write_next = pwrite;
               wdata_next = pwdata;
               cnt_next   = 4'd0;
               state_next = (WAIT_STATES == 0) ? DONE : WAIT;
            end
         end
         WAIT: begin
            if (!psel) begin
               state_next = IDLE;
            end else if (cnt_reg == CNT_LAST) begin
               state_next = DONE;
            end else begin
               cnt_next = cnt_reg + 4'd1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Read mux on the address that will be current in DONE.
   always_comb begin
      rd_data = '0;
      case (addr_next)
         A_DATA_OUT:   rd_data = data_out_reg;
         A_DIR:        rd_data = dir_reg;
         A_DATA_IN:    rd_data = sync2_reg;
         A_IRQ_EN:     rd_data = irq_en_reg;
         A_IRQ_STATUS: rd_data = irq_status_reg;
         A_IRQ_EDGE:   rd_data = irq_edge_reg;
         default:      rd_data = '0;
      endcase
   end

   // Register writes commit at the edge ending DONE; hardware set beats W1C.
   always_comb begin
      data_out_next = data_out_reg;
      dir_next      = dir_reg;
      irq_en_next   = irq_en_reg;
      irq_edge_next = irq_edge_reg;
      w1c_mask      = '0;
      if (state_reg == DONE && write_reg) begin
         case (addr_reg)
            A_DATA_OUT:   data_out_next = wdata_reg;
            A_DIR:        dir_next      = wdata_reg;
            A_IRQ_EN:     irq_en_next   = wdata_reg;
            A_IRQ_STATUS: w1c_mask      = wdata_reg;
            A_IRQ_EDGE:   irq_edge_next = wdata_reg;
            A_OUT_SET:    data_out_next = data_out_reg | wdata_reg;
            A_OUT_CLR:    data_out_next = data_out_reg & ~wdata_reg;
            default:      data_out_next = data_out_reg;
         endcase
      end
      irq_status_next = (irq_status_reg & ~w1c_mask) | event_vec;
   end

   // FSM, request latch and registered bus outputs.
   always_ff @(posedge pclk) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= 4'd0;
         addr_reg   <= '0;
         write_reg  <= 1'b0;
         wdata_reg  <= '0;
         pready_reg <= 1'b0;
         prdata_reg <= '0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         addr_reg   <= addr_next;
         write_reg  <= write_next;
         wdata_reg  <= wdata_next;
         pready_reg <= (state_next == DONE);
         prdata_reg <= (state_next == DONE) ? rd_data : '0;
      end
   end

   // Control/status registers and the registered interrupt line.
   always_ff @(posedge pclk) begin
      if (reset) begin
         data_out_reg   <= '0;
         dir_reg        <= '0;
         irq_en_reg     <= '0;
         irq_status_reg <= '0;
         irq_edge_reg   <= '0;
         irq_reg        <= 1'b0;
      end else begin
         data_out_reg   <= data_out_next;
         dir_reg        <= dir_next;
         irq_en_reg     <= irq_en_next;
         irq_status_reg <= irq_status_next;
         irq_edge_reg   <= irq_edge_next;
         irq_reg        <= |(irq_status_reg & irq_en_reg);
      end
   end

   // Two-flop input synchroniser plus a previous-value flop for edges.
   always_ff @(posedge pclk) begin
      if (reset) begin
         sync1_reg <= '0;
         sync2_reg <= '0;
         prev_reg  <= '0;
      end else begin
         sync1_reg <= gpio_in;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
      end
   end

   assign prdata   = prdata_reg;
   assign pready   = pready_reg;
   assign gpio_out = data_out_reg;
   assign gpio_oe  = dir_reg;
   assign irq      = irq_reg;

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Directed testbench for apb_gpio_bank: one instance with one wait state,
// one with zero wait states.
module tb_apb_gpio_bank;

   logic       pclk = 1'b0;
   logic       reset;
   logic       psel, psel0, penable, pwrite;
   logic [2:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] gin, gin0;
   logic [7:0] prdata, prdata0, gout, gout0, goe, goe0;
   logic       pready, pready0, irq, irq0;

   int n_pass  = 0;
   int n_total = 0;

   always #5 pclk = ~pclk;

   apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(1)) dut (
      .pclk(pclk), .reset(reset), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
      .gpio_in(gin), .gpio_out(gout), .gpio_oe(goe), .irq(irq)
   );

   apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(0)) dut0 (
      .pclk(pclk), .reset(reset), .psel(psel0), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
      .gpio_in(gin0), .gpio_out(gout0), .gpio_oe(goe0), .irq(irq0)
   );

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Drives one APB transfer (setup + access); reports the pready latency in
   // cycles after the first access cycle, how many cycles pready was high,
   // the captured read data and whether prdata stayed 0 outside pready.
   task automatic apb_xfer(input bit sel0, input logic wr, input logic [2:0] a,
                           input logic [7:0] d, output logic [7:0] rd,
                           output int lat, output int npr, output bit zero_ok);
      lat = -1; npr = 0; zero_ok = 1'b1; rd = 8'h00;
      if (sel0) psel0 = 1'b1; else psel = 1'b1;
      penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
      tick();
      penable = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if ((sel0 ? pready0 : pready) === 1'b1) begin
            lat = i; npr = 1; rd = sel0 ? prdata0 : prdata;
            break;
         end
         if ((sel0 ? prdata0 : prdata) !== 8'h00) zero_ok = 1'b0;
      end
      psel = 1'b0; psel0 = 1'b0; penable = 1'b0;
      tick();
      if ((sel0 ? pready0 : pready) !== 1'b0) npr++;
      if ((sel0 ? prdata0 : prdata) !== 8'h00) zero_ok = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; psel = 1'b0; psel0 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 3'd0; pwdata = 8'h00; gin = 8'h02; gin0 = 8'h00;
      wait_cycles(3);
      n_total++; if (pready !== 1'b0) $display("FAIL reset_pready: got %b expected 0", pready); else n_pass++;
      n_total++; if (prdata !== 8'h00) $display("FAIL reset_prdata: got %h expected 00", prdata); else n_pass++;
      n_total++; if (gout !== 8'h00) $display("FAIL reset_gpio_out: got %h expected 00", gout); else n_pass++;
      n_total++; if (goe !== 8'h00) $display("FAIL reset_gpio_oe: got %h expected 00", goe); else n_pass++;
      n_total++; if (irq !== 1'b0) $display("FAIL reset_irq: got %b expected 0", irq); else n_pass++;
      n_total++; if (pready0 !== 1'b0) $display("FAIL reset_pready0: got %b expected 0", pready0); else n_pass++;
      reset = 1'b0;
      tick();
      $display("reset: released");
   endtask

   task automatic test_write_read();
      logic [7:0] rd; int lat, npr; bit z;
      apb_xfer(1'b0, 1'b1, 3'd0, 8'hA5, rd, lat, npr, z);
      $display("write addr0 A5: lat=%0d npr=%0d", lat, npr);
      n_total++; if (lat !== 2) $display("FAIL wr_latency: got %0d expected 2", lat); else n_pass++;
      n_total++; if (npr !== 1) $display("FAIL wr_pready_count: got %0d expected 1", npr); else n_pass++;
      n_total++; if (gout !== 8'hA5) $display("FAIL wr_gpio_out: got %h expected a5", gout); else n_pass++;
      apb_xfer(1'b0, 1'b0, 3'd0, 8'h00, rd, lat, npr, z);
      $display("read addr0: data=%h lat=%0d npr=%0d", rd, lat, npr);
      n_total++; if (lat !== 2) $display("FAIL rd_latency: got %0d expected 2", lat); else n_pass++;
      n_total++; if (npr !== 1) $display("FAIL rd_pready_count: got %0d expected 1", npr); else n_pass++;
      n_total++; if (rd !== 8'hA5) $display("FAIL rd_data: got %h expected a5", rd); else n_pass++;
      n_total++; if (z !== 1'b1) $display("FAIL rd_prdata_idle: got %b expected 1", z); else n_pass++;
   endtask

   task automatic test_set_clr();
      logic [7:0] rd; int lat, npr; bit z;
      apb_xfer(1'b0, 1'b1, 3'd0, 8'h0F, rd, lat, npr, z);
      apb_xfer(1'b0, 1'b1, 3'd6, 8'hF0, rd, lat, npr, z);
      $display("out_set F0: gpio_out=%h", gout);
      n_total++; if (gout !== 8'hFF) $display("FAIL out_set: got %h expected ff", gout); else n_pass++;
      apb_xfer(1'b0, 1'b1, 3'd7, 8'h81, rd, lat, npr, z);
      $display("out_clr 81: gpio_out=%h", gout);
      n_total++; if (gout !== 8'h7E) $display("FAIL out_clr: got %h expected 7e", gout); else n_pass++;
      apb_xfer(1'b0, 1'b0, 3'd6, 8'h00, rd, lat, npr, z);
      n_total++; if (rd !== 8'h00 || npr !== 1) $display("FAIL rd_out_set: got %h/%0d expected 00/1", rd, npr); else n_pass++;
      apb_xfer(1'b0, 1'b0, 3'd7, 8'h00, rd, lat, npr, z);
      n_total++; if (rd !== 8'h00 || npr !== 1) $display("FAIL rd_out_clr: got %h/%0d expected 00/1", rd, npr); else n_pass++;
      apb_xfer(1'b0, 1'b1, 3'd1, 8'h33, rd, lat, npr, z);
      n_total++; if (goe !== 8'h33) $display("FAIL dir_gpio_oe: got %h expected 33", goe); else n_pass++;
      apb_xfer(1'b0, 1'b0, 3'd1, 8'h00, rd, lat, npr, z);
      $display("read dir: data=%h", rd);
      n_total++; if (rd !== 8'h33) $display("FAIL rd_dir: got %h expected 33", rd); else n_pass++;
   endtask

   task automatic test_edge_irq();
      logic [7:0] rd; int lat, npr; bit z;
      apb_xfer(1'b0, 1'b1, 3'd5, 8'h01, rd, lat, npr, z);
      apb_xfer(1'b0, 1'b1, 3'd3, 8'h03, rd, lat, npr, z);
      apb_xfer(1'b0, 1'b1, 3'd4, 8'hFF, rd, lat, npr, z);
      apb_xfer(1'b0, 1'b0, 3'd4, 8'h00, rd, lat, npr, z);
      n_total++; if (rd !== 8'h00) $display("FAIL status_clear: got %h expected 00", rd); else n_pass++;
      gin = 8'h01;   // bit0 rises, bit1 falls
      wait_cycles(3);
      n_total++; if (irq !== 1'b0) $display("FAIL irq_early: got %b expected 0", irq); else n_pass++;
      tick();
      $display("edges applied: irq=%b", irq);
      n_total++; if (irq !== 1'b1) $display("FAIL irq_set: got %b expected 1", irq); else n_pass++;
      apb_xfer(1'b0, 1'b0, 3'd4, 8'h00, rd, lat, npr, z);
      n_total++; if (rd !== 8'h03) $display("FAIL status_edges: got %h expected 03", rd); else n_pass++;
      apb_xfer(1'b0, 1'b1, 3'd4, 8'h01, rd, lat, npr, z);
      apb_xfer(1'b0, 1'b0, 3'd4, 8'h00, rd, lat, npr, z);
      $display("w1c 01: status=%h irq=%b", rd, irq);
      n_total++; if (rd !== 8'h02) $display("FAIL status_w1c: got %h expected 02", rd); else n_pass++;
      n_total++; if (irq !== 1'b1) $display("FAIL irq_hold: got %b expected 1", irq); else n_pass++;
      apb_xfer(1'b0, 1'b1, 3'd4, 8'h02, rd, lat, npr, z);
      n_total++; if (irq !== 1'b1) $display("FAIL irq_lag: got %b expected 1", irq); else n_pass++;
      tick();
      $display("w1c 02: irq=%b", irq);
      n_total++; if (irq !== 1'b0) $display("FAIL irq_clear: got %b expected 0", irq); else n_pass++;
   endtask

   task automatic test_collision();
      logic [7:0] rd; int lat, npr; bit z;
      gin = 8'h00; wait_cycles(4);
      gin = 8'h01; wait_cycles(4);
      apb_xfer(1'b0, 1'b0, 3'd4, 8'h00, rd, lat, npr, z);
      n_total++; if (rd !== 8'h01) $display("FAIL coll_pre: got %h expected 01", rd); else n_pass++;
      gin = 8'h00; wait_cycles(4);
      // W1C of bit0 whose DONE cycle coincides with a new rising event
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd4; pwdata = 8'h01;
      tick();
      penable = 1'b1; gin = 8'h01;
      wait_cycles(2);
      n_total++; if (pready !== 1'b1) $display("FAIL coll_pready: got %b expected 1", pready); else n_pass++;
      psel = 1'b0; penable = 1'b0;
      tick();
      apb_xfer(1'b0, 1'b0, 3'd4, 8'h00, rd, lat, npr, z);
      $display("collision: status=%h", rd);
      n_total++; if (rd !== 8'h01) $display("FAIL coll_set_wins: got %h expected 01", rd); else n_pass++;
   endtask

   task automatic test_abort();
      logic [7:0] rd; int lat, npr; bit z;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h11;
      tick();
      penable = 1'b1;
      tick();   // now in WAIT
      psel = 1'b0; penable = 1'b0;
      tick();
      n_total++; if (pready !== 1'b0) $display("FAIL abort_pready1: got %b expected 0", pready); else n_pass++;
      tick();
      n_total++; if (pready !== 1'b0) $display("FAIL abort_pready2: got %b expected 0", pready); else n_pass++;
      n_total++; if (gout !== 8'h7E) $display("FAIL abort_gpio_out: got %h expected 7e", gout); else n_pass++;
      apb_xfer(1'b0, 1'b0, 3'd0, 8'h00, rd, lat, npr, z);
      $display("abort: data_out=%h", rd);
      n_total++; if (rd !== 8'h7E) $display("FAIL abort_data_out: got %h expected 7e", rd); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] rd; int lat, npr; bit z, seen;
      n_total++; if (irq !== 1'b1) $display("FAIL rmid_pre_irq: got %b expected 1", irq); else n_pass++;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h55;
      tick();
      penable = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (pready === 1'b1) begin seen = 1'b1; break; end
      end
      n_total++; if (seen !== 1'b1) $display("FAIL rmid_pready_seen: got %b expected 1", seen); else n_pass++;
      reset = 1'b1;
      tick();
      $display("reset in DONE: out=%h oe=%h irq=%b pready=%b", gout, goe, irq, pready);
      n_total++; if (gout !== 8'h00) $display("FAIL rmid_gpio_out: got %h expected 00", gout); else n_pass++;
      n_total++; if (goe !== 8'h00) $display("FAIL rmid_gpio_oe: got %h expected 00", goe); else n_pass++;
      n_total++; if (irq !== 1'b0) $display("FAIL rmid_irq: got %b expected 0", irq); else n_pass++;
      n_total++; if (pready !== 1'b0 || prdata !== 8'h00) $display("FAIL rmid_bus: got %b/%h expected 0/00", pready, prdata); else n_pass++;
      reset = 1'b0; psel = 1'b0; penable = 1'b0;
      tick();
      apb_xfer(1'b0, 1'b0, 3'd0, 8'h00, rd, lat, npr, z);
      n_total++; if (rd !== 8'h00) $display("FAIL rmid_no_write: got %h expected 00", rd); else n_pass++;
   endtask

   task automatic test_zero_wait();
      logic [7:0] rd; int lat, npr; bit z;
      apb_xfer(1'b1, 1'b1, 3'd1, 8'h0F, rd, lat, npr, z);
      $display("zw write dir 0F: lat=%0d npr=%0d oe=%h", lat, npr, goe0);
      n_total++; if (lat !== 1) $display("FAIL zw_latency: got %0d expected 1", lat); else n_pass++;
      n_total++; if (npr !== 1) $display("FAIL zw_pready_count: got %0d expected 1", npr); else n_pass++;
      n_total++; if (goe0 !== 8'h0F) $display("FAIL zw_gpio_oe: got %h expected 0f", goe0); else n_pass++;
      gin0 = 8'h3C;   // applied with the setup cycle: one cycle too early to see
      apb_xfer(1'b1, 1'b0, 3'd2, 8'h00, rd, lat, npr, z);
      n_total++; if (rd !== 8'h00) $display("FAIL zw_data_in_early: got %h expected 00", rd); else n_pass++;
      apb_xfer(1'b1, 1'b0, 3'd2, 8'h00, rd, lat, npr, z);
      $display("zw read data_in: data=%h", rd);
      n_total++; if (rd !== 8'h3C) $display("FAIL zw_data_in: got %h expected 3c", rd); else n_pass++;
      gin0 = 8'hC3;   // applied two cycles before the access is sampled
      tick();
      apb_xfer(1'b1, 1'b0, 3'd2, 8'h00, rd, lat, npr, z);
      n_total++; if (rd !== 8'hC3) $display("FAIL zw_data_in_2cyc: got %h expected c3", rd); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_set_clr();
      test_edge_irq();
      test_collision();
      test_abort();
      test_reset_mid();
      test_zero_wait();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
